// File: rtl/lmg_pkg.sv
// Shared constants and slot helpers for the legal move generator datapath.
package lmg_pkg;

    localparam int SLOTS          = 8;
    localparam int MV_W           = 19;
    localparam int WORD_W         = 160;
    localparam int CNT_W          = 8;
    localparam int IDX_W          = 3;
    localparam int MV_INVALID_BIT = 18;

    localparam int MV_FROM_HI = 11;
    localparam int MV_FROM_LO = 6;
    localparam int MV_TO_HI   = 5;
    localparam int MV_TO_LO   = 0;

    // Slot 1 sits just below the unused top byte; idx 0 selects slot 1.
    function automatic logic [MV_W-1:0] slot_of(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
        return word[(SLOTS*MV_W-1) - MV_W*int'(idx) -: MV_W];
    endfunction

endpackage

// File: rtl/lmg_slot_mux.sv
// Selects one move slot out of a held FIFO word and flags it when invalid.
module lmg_slot_mux
    import lmg_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [MV_W-1:0]   slot,
    output logic              invalid
);

    logic [WORD_W-SLOTS*MV_W-1:0] unused_hi;

    assign unused_hi = word[WORD_W-1:SLOTS*MV_W];

    always_comb begin
        slot    = slot_of(word, idx);
        invalid = slot[MV_INVALID_BIT];
    end

endmodule

// File: rtl/lmg_move_drain.sv
// Drains the LMG output FIFO after the generator finishes and streams the
// valid moves out one per handshake, counting accepted moves.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing happening, all outputs low
// WAIT_DONE | drain armed, waiting for the generator to finish
// READ      | pop a word if the FIFO has one, else finish
// LATCH     | FIFO read data valid this cycle, capture it
// SCAN      | walk the eight slots, skip invalid, offer valid downstream
// FINISH    | FIFO drained, done held until the next start
module lmg_move_drain #(
    parameter int SLOTS  = 8,
    parameter int MV_W   = 19,
    parameter int WORD_W = 160,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              lmg_done,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_out,
    output logic              rden,
    output logic              mv_valid,
    input  logic              mv_ready,
    output logic [MV_W-1:0]   mv_data,
    output logic [5:0]        mv_from,
    output logic [5:0]        mv_to,
    output logic [CNT_W-1:0]  move_count,
    output logic              done,
    output logic              busy
);
    import lmg_pkg::*;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_READ      = 3'd2,
        ST_LATCH     = 3'd3,
        ST_SCAN      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx;
    logic [MV_W-1:0]   slot;
    logic              slot_invalid;
    logic              advance;
    logic              restart;

    lmg_slot_mux u_slot_mux (
        .word    (word_q),
        .idx     (idx),
        .slot    (slot),
        .invalid (slot_invalid)
    );

    assign restart = start && ((state == ST_IDLE) || (state == ST_FINISH));

    always_comb begin
        next_state = state;
        rden       = 1'b0;
        mv_valid   = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (lmg_done) next_state = ST_READ;
            end
            ST_READ: begin
                if (fifo_empty) begin
                    next_state = ST_FINISH;
                end else begin
                    rden       = 1'b1;
                    next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                next_state = ST_SCAN;
            end
            ST_SCAN: begin
                if (slot_invalid) begin
                    advance = 1'b1;
                end else begin
                    mv_valid = 1'b1;
                    advance  = mv_ready;
                end
                if (advance && (idx == IDX_W'(SLOTS-1))) next_state = ST_READ;
            end
            ST_FINISH: begin
                if (start) next_state = ST_WAIT_DONE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            idx        <= '0;
            move_count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_LATCH) begin
                word_q <= fifo_out;
                idx    <= '0;
            end else if (advance) begin
                idx <= idx + IDX_W'(1);
            end
            // Count saturates rather than wrapping so a huge drain never reads small.
            if (restart) begin
                move_count <= '0;
            end else if (mv_valid && mv_ready && (move_count != '1)) begin
                move_count <= move_count + CNT_W'(1);
            end
        end
    end

    assign mv_data = mv_valid ? slot : '0;
    assign mv_from = mv_data[MV_FROM_HI:MV_FROM_LO];
    assign mv_to   = mv_data[MV_TO_HI:MV_TO_LO];
    assign done    = (state == ST_FINISH);
    assign busy    = (state != ST_IDLE) && (state != ST_FINISH);

endmodule

// File: tb/tb_lmg_move_drain.sv
// Directed and randomized bench for lmg_move_drain with a FIFO model and a
// queue of expected moves built from the slot rules.
module tb_lmg_move_drain;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         lmg_done;
    logic         fifo_empty;
    logic [159:0] fifo_out;
    logic         rden;
    logic         mv_valid;
    logic         mv_ready;
    logic [18:0]  mv_data;
    logic [5:0]   mv_from;
    logic [5:0]   mv_to;
    logic [7:0]   move_count;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    lmg_move_drain dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lmg_done   (lmg_done),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out),
        .rden       (rden),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .mv_data    (mv_data),
        .mv_from    (mv_from),
        .mv_to      (mv_to),
        .move_count (move_count),
        .done       (done),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [159:0] fifo_q[$];
    logic [18:0]  exp_q[$];
    logic [18:0]  sl[8];
    logic [18:0]  sl_saved[8];
    int           exp_total;
    int           cyc;
    int           accepted;
    int           rden_cnt;
    int           valid_cyc;
    bit           rand_ready;
    bit           stalled;
    bit           rden_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a FIFO word built from sl[] and record which moves must appear.
    task automatic add_word();
        fifo_q.push_back({8'h00, sl[0], sl[1], sl[2], sl[3], sl[4], sl[5], sl[6], sl[7]});
        for (int i = 0; i < 8; i++) begin
            if (sl[i][18] == 1'b0) begin
                exp_q.push_back(sl[i]);
                exp_total++;
            end
        end
        fifo_empty = 1'b0;
    endtask

    function automatic logic [18:0] rnd_valid();
        return {1'b0, 18'($urandom)};
    endfunction

    function automatic logic [18:0] rnd_invalid();
        return {1'b1, 18'($urandom)};
    endfunction

    // One clock: observe at the falling edge, model the FIFO after the rising edge.
    task automatic tick();
        bit did_rd;
        @(negedge clk);
        if (mv_valid) begin
            valid_cyc++;
            if (exp_q.size() == 0) begin
                chk("extra_move", 32'(mv_valid), 32'd0);
            end else begin
                chk("mv_data", 32'(mv_data), 32'(exp_q[0]));
                chk("mv_from", 32'(mv_from), 32'(exp_q[0][11:6]));
                chk("mv_to",   32'(mv_to),   32'(exp_q[0][5:0]));
                if (mv_ready) begin
                    void'(exp_q.pop_front());
                    accepted++;
                end
            end
        end else if (stalled) begin
            chk("valid_dropped", 32'(mv_valid), 32'd1);
        end
        stalled = mv_valid && !mv_ready;
        chk("rden_pulse", 32'(rden & rden_prev), 32'd0);
        chk("rden_on_empty", 32'(rden & fifo_empty), 32'd0);
        if (rden) rden_cnt++;
        rden_prev = rden;
        did_rd    = rden;
        @(posedge clk);
        #1;
        if (did_rd && fifo_q.size() > 0) fifo_out = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
        if (rand_ready) mv_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic begin_test();
        exp_q.delete();
        exp_total = 0;
        accepted  = 0;
        rden_cnt  = 0;
        valid_cyc = 0;
        stalled   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("moves_left", 32'(exp_q.size()), 32'd0);
        chk("move_count", 32'(move_count), (exp_total > 255) ? 32'd255 : 32'(exp_total));
        chk("end_valid", 32'(mv_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        lmg_done   = 1'b0;
        fifo_empty = 1'b1;
        fifo_out   = '0;
        mv_ready   = 1'b0;
        rand_ready = 1'b0;
        rden_prev  = 1'b0;
        begin_test();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rden", 32'(rden), 32'd0);
        chk("rst_valid", 32'(mv_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);

        // Slots 1, 3, 8 valid; latency and finish timing with ready high.
        begin_test();
        for (int i = 0; i < 8; i++) sl[i] = rnd_invalid();
        sl[0] = {1'b0, 6'($urandom), 6'o12, 6'o34};
        sl[2] = {1'b0, 6'($urandom), 6'o01, 6'o02};
        sl[7] = {1'b0, 6'($urandom), 6'o63, 6'o00};
        add_word();
        mv_ready = 1'b1;
        lmg_done = 1'b1;
        do_start();
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_rden", 32'(rden), 32'd0);
        tick();
        chk("c2_rden", 32'(rden), 32'd1);
        tick();
        chk("c3_rden", 32'(rden), 32'd0);
        chk("c3_valid", 32'(mv_valid), 32'd0);
        tick();
        chk("c4_valid", 32'(mv_valid), 32'd1);
        run_drain(100);
        chk("t1_done_cycle", 32'(cyc), 32'd13);
        chk("t1_accepted", 32'(accepted), 32'd3);
        chk("t1_valid_cycles", 32'(valid_cyc), 32'd3);

        // Two full words; lmg_done dropped after it has been seen.
        begin_test();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) sl[i] = rnd_valid();
            add_word();
        end
        do_start();
        tick();
        lmg_done = 1'b0;
        run_drain(100);
        chk("t2_rden_pulses", 32'(rden_cnt), 32'd2);
        chk("t2_done_cycle", 32'(cyc), 32'd23);
        chk("t2_valid_cycles", 32'(valid_cyc), 32'd16);

        // Backpressure on the second move for five cycles.
        begin_test();
        for (int i = 0; i < 8; i++) sl[i] = rnd_valid();
        add_word();
        lmg_done = 1'b1;
        do_start();
        for (int n = 0; n < 20 && accepted < 1; n++) tick();
        chk("bp_first_taken", 32'(accepted), 32'd1);
        mv_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_held_valid", 32'(mv_valid), 32'd1);
        end
        chk("bp_no_take", 32'(accepted), 32'd1);
        mv_ready = 1'b1;
        run_drain(100);
        chk("bp_accepted", 32'(accepted), 32'd8);

        // lmg_done held low for 20 cycles after start.
        begin_test();
        for (int i = 0; i < 8; i++) sl[i] = ($urandom_range(0, 1) != 0) ? rnd_valid() : rnd_invalid();
        sl[3] = rnd_valid();
        add_word();
        lmg_done = 1'b0;
        do_start();
        for (int n = 0; n < 20; n++) begin
            chk("wait_rden", 32'(rden), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            tick();
        end
        lmg_done = 1'b1;
        run_drain(100);
        chk("wait_rden_pulses", 32'(rden_cnt), 32'd1);

        // Empty FIFO when lmg_done is seen.
        begin_test();
        do_start();
        tick();
        chk("empty_c2_done", 32'(done), 32'd0);
        tick();
        chk("empty_c3_done", 32'(done), 32'd1);
        run_drain(10);
        chk("empty_valid_cycles", 32'(valid_cyc), 32'd0);
        chk("empty_rden", 32'(rden_cnt), 32'd0);

        // Reset while slot 4 is offered; the next start drains the following word.
        begin_test();
        for (int i = 0; i < 8; i++) sl[i] = rnd_valid();
        add_word();
        for (int i = 0; i < 8; i++) begin
            sl[i]       = ($urandom_range(0, 2) != 0) ? rnd_valid() : rnd_invalid();
            sl_saved[i] = sl[i];
        end
        add_word();
        do_start();
        for (int n = 0; n < 20 && accepted < 3; n++) tick();
        chk("rst_mid_taken", 32'(accepted), 32'd3);
        mv_ready = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        mv_ready = 1'b1;
        stalled  = 1'b0;
        chk("mid_rst_rden", 32'(rden), 32'd0);
        chk("mid_rst_valid", 32'(mv_valid), 32'd0);
        chk("mid_rst_data", 32'(mv_data), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(move_count), 32'd0);
        begin_test();
        for (int i = 0; i < 8; i++) sl[i] = sl_saved[i];
        fifo_q.delete();
        add_word();
        do_start();
        run_drain(100);
        chk("redrain_rden", 32'(rden_cnt), 32'd1);

        // Randomized drains with random slot validity and backpressure.
        for (int it = 0; it < 6; it++) begin
            int nw;
            int dly;
            begin_test();
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                for (int i = 0; i < 8; i++) sl[i] = ($urandom_range(0, 2) != 0) ? rnd_valid() : rnd_invalid();
                add_word();
            end
            lmg_done   = 1'b0;
            rand_ready = 1'b1;
            do_start();
            dly = $urandom_range(0, 5);
            for (int n = 0; n < dly; n++) tick();
            lmg_done = 1'b1;
            run_drain(600);
            chk("rand_rden_pulses", 32'(rden_cnt), 32'(nw));
        end
        rand_ready = 1'b0;
        mv_ready   = 1'b1;

        // Saturation: 33 full words exceed the 8-bit counter.
        begin_test();
        for (int w = 0; w < 33; w++) begin
            for (int i = 0; i < 8; i++) sl[i] = rnd_valid();
            add_word();
        end
        do_start();
        run_drain(500);
        chk("sat_accepted", 32'(accepted), 32'd264);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
